// File: rtl/axis_wrr_packet_arbiter_pkg.sv
// Shared types for the packet-level WRR arbiter: AXI-Stream beat structs,
// the arbiter state enum and the rotating priority pick helper.
package axis_arb_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int RR_MAX_CH       = 16;
    localparam int RR_IDX_W        = 4;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic                       tlast;
        logic                       tvalid;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Rotate so that ptr sits at bit 0, find the first set bit, then map back.
    // Result is {found, index}; n is the number of live channels (<= RR_MAX_CH).
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX_CH-1:0] valid_vec,
        input logic [RR_IDX_W-1:0]  ptr,
        input logic [RR_IDX_W:0]    n
    );
        logic [RR_MAX_CH-1:0] rot;
        logic [RR_IDX_W:0]    src;
        logic [RR_IDX_W:0]    first;
        logic [RR_IDX_W:0]    idx;
        logic                 found;
        rot   = '0;
        found = 1'b0;
        first = '0;
        for (int i = 0; i < RR_MAX_CH; i++) begin
            src = {1'b0, ptr} + (RR_IDX_W+1)'(i);
            if (src >= n) src = src - n;
            if (i < int'(n)) rot[i] = valid_vec[RR_IDX_W'(src)];
        end
        for (int i = RR_MAX_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                first = (RR_IDX_W+1)'(i);
            end
        end
        idx = {1'b0, ptr} + first;
        if (idx >= n) idx = idx - n;
        return {found, RR_IDX_W'(idx)};
    endfunction

endpackage

// File: rtl/axis_wrr_packet_arbiter_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo CHANNEL_NUMBER.
module rr_priority_picker
    import axis_arb_pkg::*;
#(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  logic [CHANNEL_NUMBER-1:0]       valid_i,
    input  logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_i,
    output logic                            found_o,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] idx_o
);

    logic [RR_IDX_W:0] pick;

    always_comb begin
        pick = rr_pick(RR_MAX_CH'(valid_i), RR_IDX_W'(ptr_i), (RR_IDX_W+1)'(CHANNEL_NUMBER));
    end

    assign found_o = pick[RR_IDX_W];
    assign idx_o   = CHANNEL_NUMBER_WIDTH'(pick[RR_IDX_W-1:0]);

endmodule

// File: rtl/axis_wrr_packet_arbiter.sv
// Packet-level weighted round-robin merge of CHANNEL_NUMBER AXI-Stream inputs
// onto one output; a grant lasts up to weight packets before rotating.
//
//   state | meaning
//   IDLE  | no grant; scan requests from rr_ptr, register winner and credit
//   GRANT | zero-latency pass-through of granted input until credit runs out
module axis_wrr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH           = AXIS_DATA_WIDTH,
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int WEIGHT_WIDTH         = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  axis_mosi_t [CHANNEL_NUMBER-1:0]              in_mosi_i,
    output axis_miso_t [CHANNEL_NUMBER-1:0]              in_miso_o,
    output axis_mosi_t                                   out_mosi_o,
    input  axis_miso_t                                   out_miso_i,
    input  logic [CHANNEL_NUMBER-1:0][WEIGHT_WIDTH-1:0]  weight_i,
    output logic [CHANNEL_NUMBER_WIDTH-1:0]              grant_o,
    output logic                                         busy_o
);

    if (DATA_WIDTH != AXIS_DATA_WIDTH || CHANNEL_NUMBER < 2 || CHANNEL_NUMBER > RR_MAX_CH) begin : g_param_check
        $error("axis_wrr_packet_arbiter: unsupported parameter set");
    end

    arb_state_e                      state_q, state_d;
    logic [CHANNEL_NUMBER_WIDTH-1:0] grant_q, grant_d;
    logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_WIDTH-1:0]         credit_q, credit_d;

    logic [CHANNEL_NUMBER-1:0]       req_vec;
    logic                            pick_found;
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick_idx;
    logic [WEIGHT_WIDTH-1:0]         weight_pick;
    axis_mosi_t                      sel_mosi;
    logic                            eop;

    always_comb begin
        for (int i = 0; i < CHANNEL_NUMBER; i++) req_vec[i] = in_mosi_i[i].tvalid;
    end

    rr_priority_picker #(
        .CHANNEL_NUMBER       (CHANNEL_NUMBER),
        .CHANNEL_NUMBER_WIDTH (CHANNEL_NUMBER_WIDTH)
    ) u_picker (
        .valid_i (req_vec),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign weight_pick = weight_i[pick_idx];
    assign sel_mosi    = in_mosi_i[grant_q];
    assign eop         = sel_mosi.tvalid & out_miso_i.tready & sel_mosi.tlast;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        credit_d   = credit_q;
        out_mosi_o = '0;
        in_miso_o  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    credit_d = (weight_pick == '0) ? WEIGHT_WIDTH'(1) : weight_pick;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                out_mosi_o                = sel_mosi;
                in_miso_o[grant_q].tready = out_miso_i.tready;
                if (eop) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                    // Remaining credit keeps the grant with no arbitration bubble.
                    if (credit_d == '0 || !sel_mosi.tvalid) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1))
                                 ? '0 : grant_q + CHANNEL_NUMBER_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_axis_wrr_packet_arbiter.sv
// Scenario bench for the WRR packet arbiter: packet sources, an output beat
// log and an order model derived from the turn/credit rules.
module tb_axis_wrr_packet_arbiter;
    import axis_arb_pkg::*;

    localparam int CN   = 5;
    localparam int MAXP = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    axis_mosi_t [CN-1:0]  in_mosi;
    axis_miso_t [CN-1:0]  in_miso;
    axis_mosi_t           out_mosi;
    axis_miso_t           out_miso;
    logic [CN-1:0][3:0]   weight;
    logic [2:0]           grant;
    logic                 busy;

    axis_wrr_packet_arbiter #(
        .DATA_WIDTH(32), .CHANNEL_NUMBER(CN), .WEIGHT_WIDTH(4)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_mosi_i(in_mosi), .in_miso_o(in_miso),
        .out_mosi_o(out_mosi), .out_miso_i(out_miso), .weight_i(weight),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;

    int len_tab [CN][MAXP];
    int n_pkts  [CN];
    int pkt_cnt [CN];
    int beat_idx[CN];
    bit src_en  [CN];
    bit src_pause[CN];

    int          log_cyc[$];
    int          log_ch[$];
    logic [31:0] log_data[$];
    bit          log_last[$];

    int          exp_ch[$];
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    bit          exp_turn_first[$];

    bit          s_valid, s_last, s_busy, s_ready;
    logic [31:0] s_data;
    int          s_grant;
    bit          s_tready[CN];

    function automatic logic [31:0] enc(input int ch, input int pkt, input int beat);
        return {ch[3:0], pkt[11:0], beat[7:0], 8'h5A};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < CN; i++) begin
            int k;
            k = (pkt_cnt[i] < MAXP) ? pkt_cnt[i] : MAXP - 1;
            in_mosi[i].tvalid = src_en[i] && !src_pause[i] && (pkt_cnt[i] < n_pkts[i]);
            in_mosi[i].tdata  = enc(i, pkt_cnt[i], beat_idx[i]);
            in_mosi[i].tlast  = (pkt_cnt[i] < n_pkts[i]) && (beat_idx[i] == len_tab[i][k] - 1);
        end
    endtask

    // One clock: drive at edge+1, sample at negedge, advance sources after the edge.
    task automatic step();
        bit hs[CN];
        drive_inputs();
        @(negedge clk);
        s_valid = out_mosi.tvalid;
        s_data  = out_mosi.tdata;
        s_last  = out_mosi.tlast;
        s_grant = int'(grant);
        s_busy  = busy;
        s_ready = out_miso.tready;
        for (int i = 0; i < CN; i++) begin
            s_tready[i] = in_miso[i].tready;
            hs[i] = in_mosi[i].tvalid && in_miso[i].tready;
            if (s_tready[i] && (!s_busy || s_grant != i)) viol++;
        end
        if (s_valid && s_ready) begin
            log_cyc.push_back(cyc);
            log_ch.push_back(s_grant);
            log_data.push_back(s_data);
            log_last.push_back(s_last);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < CN; i++) begin
            if (hs[i]) begin
                beat_idx[i]++;
                if (beat_idx[i] >= len_tab[i][pkt_cnt[i]]) begin
                    beat_idx[i] = 0;
                    pkt_cnt[i]++;
                end
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < CN; i++) begin
            src_en[i] = 0; src_pause[i] = 0; n_pkts[i] = 0; pkt_cnt[i] = 0; beat_idx[i] = 0;
            for (int p = 0; p < MAXP; p++) len_tab[i][p] = 1;
        end
        log_cyc.delete(); log_ch.delete(); log_data.delete(); log_last.delete();
        viol = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        drive_inputs();
        out_miso.tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Order model: each turn goes to the first enabled channel at or after the
    // pointer, which then sends max(weight,1) packets; pointer moves past it.
    task automatic build_expected(input int n_pk, input logic [CN-1:0][3:0] w);
        int ptr, np, g, cr, c;
        int nxt[CN];
        exp_ch.delete(); exp_data.delete(); exp_last.delete(); exp_turn_first.delete();
        for (int i = 0; i < CN; i++) nxt[i] = 0;
        ptr = 0; np = 0;
        while (np < n_pk) begin
            g = -1;
            for (int k = 0; k < CN; k++) begin
                c = (ptr + k) % CN;
                if (g < 0 && src_en[c] && nxt[c] < n_pkts[c]) g = c;
            end
            if (g < 0) break;
            cr = (w[g] == 4'd0) ? 1 : int'(w[g]);
            for (int p = 0; p < cr && np < n_pk; p++) begin
                for (int b = 0; b < len_tab[g][nxt[g]]; b++) begin
                    exp_ch.push_back(g);
                    exp_data.push_back(enc(g, nxt[g], b));
                    exp_last.push_back(b == len_tab[g][nxt[g]] - 1);
                    exp_turn_first.push_back(p == 0 && b == 0);
                end
                nxt[g]++;
                np++;
            end
            ptr = (g + 1) % CN;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_sources();
        src_en[0] = 1; n_pkts[0] = 1;
        drive_inputs();
        out_miso.tready = 1'b1;
        weight = '0;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (grant !== 3'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant); end
        total++; if (in_miso !== '0) begin bad++; $display("FAIL reset_tready: got %0h want 0", in_miso); end
        total++; if (out_mosi.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %0b want 0", out_mosi.tvalid); end
        clear_sources();
        drive_inputs();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL idle_no_req: busy got %0b want 0", s_busy); end
    endtask

    task automatic test_single_source();
        int c0;
        do_reset();
        for (int i = 0; i < CN; i++) weight[i] = 4'd1;
        src_en[2] = 1; n_pkts[2] = 1; len_tab[2][0] = 4;
        c0 = cyc;
        step();
        total++; if (s_busy !== 1'b0 || log_data.size() != 0) begin
            bad++; $display("FAIL single_bubble: busy=%0b beats=%0d want 0/0", s_busy, log_data.size()); end
        step();
        total++; if (s_grant != 2 || !s_busy) begin
            bad++; $display("FAIL single_grant: got grant=%0d busy=%0b want 2/1", s_grant, s_busy); end
        for (int k = 0; k < 20 && log_data.size() < 4; k++) step();
        total++; if (log_data.size() != 4) begin bad++; $display("FAIL single_timeout: beats got %0d want 4", log_data.size()); end
        for (int b = 0; b < 4 && b < log_data.size(); b++) begin
            total++;
            if (log_data[b] !== enc(2, 0, b) || log_last[b] != (b == 3) || log_cyc[b] != c0 + 1 + b) begin
                bad++; $display("FAIL single_beat%0d: got data=%h last=%0b cyc=%0d want %h/%0b/%0d",
                                b, log_data[b], log_last[b], log_cyc[b], enc(2, 0, b), b == 3, c0 + 1 + b);
            end
        end
        step();
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL single_back_idle: busy got %0b want 0", s_busy); end
        src_en[0] = 1; src_en[3] = 1; src_en[4] = 1;
        n_pkts[0] = 1; n_pkts[3] = 1; n_pkts[4] = 1;
        for (int k = 0; k < 20 && log_data.size() < 5; k++) step();
        total++; if (log_data.size() < 5 || log_ch[4] != 3) begin
            bad++; $display("FAIL single_rr_ptr: next grant got %0d want 3", (log_data.size() < 5) ? -1 : log_ch[4]); end
    endtask

    task automatic test_all_channels();
        int c0;
        do_reset();
        for (int i = 0; i < CN; i++) begin weight[i] = 4'd1; src_en[i] = 1; n_pkts[i] = 2; end
        c0 = cyc;
        for (int k = 0; k < 60 && log_data.size() < 10; k++) step();
        total++; if (log_data.size() != 10) begin bad++; $display("FAIL all_timeout: beats got %0d want 10", log_data.size()); end
        for (int i = 0; i < 10 && i < log_data.size(); i++) begin
            int want_cyc;
            want_cyc = (i == 0) ? c0 + 1 : log_cyc[i-1] + 2;
            total++;
            if (log_ch[i] != i % CN || log_data[i] !== enc(i % CN, i / CN, 0) || log_cyc[i] != want_cyc) begin
                bad++; $display("FAIL all_order%0d: got ch=%0d cyc=%0d want ch=%0d cyc=%0d",
                                i, log_ch[i], log_cyc[i], i % CN, want_cyc);
            end
        end
    endtask

    task automatic test_weighted();
        int c0;
        do_reset();
        weight = '0;
        weight[0] = 4'd3; weight[1] = 4'd1;
        src_en[0] = 1; src_en[1] = 1; n_pkts[0] = 30; n_pkts[1] = 30;
        for (int p = 0; p < MAXP; p++) begin len_tab[0][p] = 2; len_tab[1][p] = 2; end
        build_expected(12, weight);
        c0 = cyc;
        for (int k = 0; k < 200 && log_data.size() < exp_data.size(); k++) step();
        total++; if (log_data.size() < exp_data.size()) begin
            bad++; $display("FAIL weighted_timeout: beats got %0d want %0d", log_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
            int want_cyc;
            want_cyc = (i == 0) ? c0 + 1 : log_cyc[i-1] + (exp_turn_first[i] ? 2 : 1);
            total++;
            if (log_ch[i] != exp_ch[i] || log_data[i] !== exp_data[i] || log_last[i] != exp_last[i] || log_cyc[i] != want_cyc) begin
                bad++; $display("FAIL weighted_beat%0d: got ch=%0d data=%h cyc=%0d want ch=%0d data=%h cyc=%0d",
                                i, log_ch[i], log_data[i], log_cyc[i], exp_ch[i], exp_data[i], want_cyc);
            end
        end
    endtask

    task automatic test_stall_no_interleave();
        do_reset();
        for (int i = 0; i < CN; i++) weight[i] = 4'd1;
        src_en[1] = 1; n_pkts[1] = 1; len_tab[1][0] = 5;
        for (int k = 0; k < 20 && log_data.size() < 2; k++) step();
        src_pause[1] = 1;
        src_en[3] = 1; n_pkts[3] = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (s_grant != 1 || !s_busy || s_tready[3] || s_valid) begin
                bad++; $display("FAIL stall_hold%0d: got grant=%0d busy=%0b rdy3=%0b valid=%0b want 1/1/0/0",
                                k, s_grant, s_busy, s_tready[3], s_valid);
            end
        end
        src_pause[1] = 0;
        for (int k = 0; k < 20 && log_data.size() < 6; k++) step();
        total++; if (log_data.size() != 6) begin bad++; $display("FAIL stall_timeout: beats got %0d want 6", log_data.size()); end
        for (int i = 0; i < 6 && i < log_data.size(); i++) begin
            logic [31:0] want;
            want = (i < 5) ? enc(1, 0, i) : enc(3, 0, 0);
            total++;
            if (log_data[i] !== want) begin
                bad++; $display("FAIL stall_order%0d: got %h want %h", i, log_data[i], want);
            end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL stall_foreign_tready: got %0d cycles want 0", viol); end
    endtask

    task automatic test_backpressure();
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < CN; i++) weight[i] = 4'd1;
        src_en[0] = 1; n_pkts[0] = 1; len_tab[0][0] = 6;
        step();
        for (int k = 0; k < 30 && log_data.size() < 6; k++) begin
            out_miso.tready = pat[k % 4];
            step();
            if (!s_ready) begin
                total++;
                if (!s_valid || s_data !== enc(0, 0, log_data.size())) begin
                    bad++; $display("FAIL bp_hold: got valid=%0b data=%h want 1/%h", s_valid, s_data, enc(0, 0, log_data.size()));
                end
            end
        end
        out_miso.tready = 1'b1;
        total++; if (log_data.size() != 6) begin bad++; $display("FAIL bp_count: beats got %0d want 6", log_data.size()); end
        for (int i = 0; i < 6 && i < log_data.size(); i++) begin
            total++;
            if (log_data[i] !== enc(0, 0, i) || log_last[i] != (i == 5)) begin
                bad++; $display("FAIL bp_beat%0d: got %h/%0b want %h/%0b", i, log_data[i], log_last[i], enc(0, 0, i), i == 5);
            end
        end
    endtask

    task automatic test_weight_change();
        int exp_seq[9];
        exp_seq = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        do_reset();
        weight = '0;
        weight[0] = 4'd2; weight[1] = 4'd1;
        src_en[0] = 1; src_en[1] = 1; n_pkts[0] = 12; n_pkts[1] = 12;
        for (int k = 0; k < 10 && log_data.size() < 1; k++) step();
        weight[0] = 4'd5;
        for (int k = 0; k < 60 && log_data.size() < 9; k++) step();
        total++; if (log_data.size() < 9) begin bad++; $display("FAIL wchg_timeout: beats got %0d want 9", log_data.size()); end
        for (int i = 0; i < 9 && i < log_data.size(); i++) begin
            total++;
            if (log_ch[i] != exp_seq[i]) begin
                bad++; $display("FAIL wchg_order%0d: got ch=%0d want %0d", i, log_ch[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < CN; i++) weight[i] = 4'd1;
        src_en[2] = 1; n_pkts[2] = 1;
        for (int k = 0; k < 10 && log_data.size() < 1; k++) step();
        step();
        src_en[4] = 1; n_pkts[4] = 1; len_tab[4][0] = 6;
        for (int k = 0; k < 20 && log_data.size() < 3; k++) step();
        drive_inputs();
        #2;
        total++; if (!busy || !in_miso[4].tready || !out_mosi.tvalid) begin
            bad++; $display("FAIL rstmid_pre: got busy=%0b rdy4=%0b valid=%0b want 1/1/1", busy, in_miso[4].tready, out_mosi.tvalid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_mosi.tvalid !== 1'b0 || in_miso !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_drop: got valid=%0b tready=%0h busy=%0b want 0/0/0", out_mosi.tvalid, in_miso, busy); end
        clear_sources();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (grant !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_after: got grant=%0d busy=%0b want 0/0", grant, busy); end
        src_en[1] = 1; src_en[3] = 1; n_pkts[1] = 1; n_pkts[3] = 1;
        for (int k = 0; k < 20 && log_data.size() < 2; k++) step();
        total++; if (log_data.size() < 2 || log_ch[0] != 1 || log_ch[1] != 3) begin
            bad++; $display("FAIL rstmid_ptr: got first=%0d want 1", (log_data.size() < 1) ? -1 : log_ch[0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int mask;
            do_reset();
            mask = $urandom_range(1, 31);
            for (int i = 0; i < CN; i++) begin
                weight[i] = 4'($urandom_range(0, 6));
                src_en[i] = mask[i];
                n_pkts[i] = 60;
                for (int p = 0; p < MAXP; p++) len_tab[i][p] = $urandom_range(1, 4);
            end
            build_expected(30, weight);
            for (int k = 0; k < 3000 && log_data.size() < exp_data.size(); k++) begin
                out_miso.tready = ($urandom_range(0, 3) != 0);
                step();
            end
            out_miso.tready = 1'b1;
            total++; if (log_data.size() < exp_data.size()) begin
                bad++; $display("FAIL rand%0d_timeout: beats got %0d want %0d", it, log_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
                total++;
                if (log_ch[i] != exp_ch[i] || log_data[i] !== exp_data[i] || log_last[i] != exp_last[i]) begin
                    bad++; $display("FAIL rand%0d_beat%0d: got ch=%0d data=%h last=%0b want ch=%0d data=%h last=%0b",
                                    it, i, log_ch[i], log_data[i], log_last[i], exp_ch[i], exp_data[i], exp_last[i]);
                end
            end
            total++; if (viol != 0) begin bad++; $display("FAIL rand%0d_foreign_tready: got %0d want 0", it, viol); end
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_all_channels();
        test_weighted();
        test_stall_no_interleave();
        test_backpressure();
        test_weight_change();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
